cache_miss_arbiter: RTL and testbench
=====================================

CACHE_MISS_ARBITER -- requirements
Module: cache_miss_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 16, meaning address width in bits.
REQ-002 The module SHALL have parameter DATA_W, default 16, meaning word width in bits (byte-addressed, DATA_W/8 bytes per word).
REQ-003 The module SHALL have parameter WORDS, default 8, meaning words per line (power of 2, at least 2).
REQ-004 The module SHALL have parameter NUM_CH, default 2, meaning number of miss channels (channel 0 = instruction, channel 1 = data).
REQ-005 The design SHALL use one clock, clk, and an asynchronous, active-high reset, rst.
REQ-006 The ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  async active-high reset
- req_valid  in  NUM_CH  per-channel miss pending
- req_addr  in  NUM_CH*ADDR_W  per-channel miss address; channel c occupies bits [c*ADDR_W +: ADDR_W]
- busy  out  1  fill in progress
- grant  out  NUM_CH  one-hot owner of the current fill
- mem_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  word address to memory
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  memory read data valid
- fill_valid  out  1  fill word valid this cycle
- fill_idx  out  log2(WORDS)  word index within the line
- fill_data  out  DATA_W  fill word
- tag_write  out  1  one-cycle pulse: write tag/valid for the filled line
- fill_done  out  NUM_CH  one-cycle one-hot pulse to the owning channel

Function
REQ-007 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-008 IDLE SHALL move to ISSUE when any req_valid is high.
- Selects one channel per the arbitration rule.
- Latches line base = req_addr with the low log2(WORDS*DATA_W/8) bits cleared.
- Sets grant.
REQ-009 ISSUE SHALL assert mem_en for exactly WORDS consecutive cycles.
- mem_addr = base + k*(DATA_W/8), k = 0..WORDS-1.
- Moves to DRAIN after the last issue.
REQ-010 In ISSUE and DRAIN, fill_valid SHALL equal mem_rvalid.
- fill_data = mem_rdata, combinational.
- fill_idx = count of words already returned in this fill.
REQ-011 DRAIN SHALL move to DONE in the cycle after the WORDS-th mem_rvalid of the fill; returns arriving during ISSUE SHALL count.
REQ-012 DONE SHALL last one cycle.
- Asserts tag_write and fill_done[owner].
- Then returns to IDLE; grant clears on entry to IDLE.
REQ-013 busy SHALL be high in ISSUE, DRAIN and DONE and low in IDLE.
REQ-014 The next arbitration SHALL occur at the earliest in the cycle after DONE.
REQ-015 mem_rvalid SHALL be ignored in IDLE and DONE, and any return beyond WORDS SHALL be ignored.
REQ-016 If the owner drops req_valid mid-fill, the fill SHALL still complete normally, including tag_write and fill_done.
REQ-017 req_addr changes after grant SHALL have no effect on the current fill.
REQ-018 Counters SHALL be log2(WORDS)+1 bits wide and SHALL not wrap within a fill.

Reset
REQ-019 While rst is high, the state SHALL be IDLE, all counters 0, and every output 0 (busy, grant, mem_en, mem_addr, fill_valid, fill_idx, fill_data, tag_write, fill_done).
REQ-020 Reset asserted mid-fill SHALL abort the fill with no tag_write or fill_done; the memory shares rst, so no stale returns follow.

Configuration
REQ-021 With CACHE_MISS_RR_ARB_EN defined, arbitration SHALL be round-robin: search starts at the channel after the last granted one (initially channel 0), and a last-grant pointer (reset 0) is kept.
REQ-022 Without CACHE_MISS_RR_ARB_EN, arbitration SHALL be fixed priority, lowest index first, and no pointer state SHALL exist.

Structure
REQ-023 Package cache_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-024 Arbitration SHALL live in sub-module miss_arbiter (req vector in, one-hot grant out, pointer state under the macro).

Verification (WORDS=8, DATA_W=16, NUM_CH=2, memory latency 4)
REQ-025 Single miss:
- Stimulus: req_valid=01, addr 0x1234 at cycle 0.
- Response: grant=01; mem_addr 0x1230..0x123E on cycles 1..8; fill_valid on cycles 5..12 with fill_idx 0..7; tag_write and fill_done=01 at cycle 13; busy low at cycle 14.
REQ-026 Simultaneous misses:
- Stimulus: req_valid=11, ch0 0x0040, ch1 0x8008.
- Response: ch0 is served first (base 0x0040); ch1 is then served with base 0x8000, granted in the cycle after ch0 DONE.
REQ-027 Round-robin:
- Stimulus: CACHE_MISS_RR_ARB_EN defined, req_valid held at 11 for four fills.
- Response: grant order 01, 10, 01, 10; without the macro, 01, 01, 01, 01 while ch0 keeps re-requesting.
REQ-028 Reset mid-fill:
- Stimulus: rst pulsed at cycle 6 of a fill.
- Response: all outputs 0 next cycle, no tag_write; a fresh request afterwards completes normally.
REQ-029 Requester drop and spurious returns:
- Stimulus: owner drops req_valid at cycle 3.
- Response: fill still ends with fill_done; extra mem_rvalid pulses in IDLE produce no fill_valid.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and default parameter constants for the cache miss fill path.
package cache_pkg;

  localparam int unsigned AddrWDefault = 16;
  localparam int unsigned DataWDefault = 16;
  localparam int unsigned WordsDefault = 8;
  localparam int unsigned NumChDefault = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } fill_state_e;

endpackage

// File: rtl/miss_arbiter.sv
// Picks one pending miss channel. Round-robin when CACHE_MISS_RR_ARB_EN is defined,
// otherwise fixed priority with channel 0 highest.
module miss_arbiter #(
  parameter int unsigned NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              update,
  output logic [NUM_CH-1:0] grant
);

`ifdef CACHE_MISS_RR_ARB_EN
  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // ptr_q holds the search start, i.e. the channel after the last granted one.
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!found && req[c] &&
            ((32'(ptr_q) + i == c) || (32'(ptr_q) + i == c + NUM_CH))) begin
          found    = 1'b1;
          grant[c] = 1'b1;
          ptr_d    = (c == NUM_CH - 1) ? '0 : PTR_W'(c + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (update) begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_rr;
  logic found;

  assign unused_rr = ^{clk, rst, update};

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cache_miss_arbiter.sv
// Serialises cache line fills from several miss channels onto one memory read port.
// Define CACHE_MISS_RR_ARB_EN for round-robin arbitration (fixed priority otherwise).
module cache_miss_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned WORDS  = WordsDefault,
  parameter int unsigned NUM_CH = NumChDefault
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  output logic                       busy,
  output logic [NUM_CH-1:0]          grant,
  output logic                       mem_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_rvalid,
  output logic                       fill_valid,
  output logic [$clog2(WORDS)-1:0]   fill_idx,
  output logic [DATA_W-1:0]          fill_data,
  output logic                       tag_write,
  output logic [NUM_CH-1:0]          fill_done
);

  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(WORDS * BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  fill_state_e       state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;

  logic [NUM_CH-1:0] arb_grant;
  logic              arb_update;
  logic [ADDR_W-1:0] sel_addr;
  logic              accept;

  miss_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_miss_arbiter (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .update (arb_update),
    .grant  (arb_grant)
  );

  always_comb begin
    sel_addr = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sel_addr |= req_addr[c*ADDR_W +: ADDR_W] & {ADDR_W{arb_grant[c]}};
    end
  end

  // Returns past the WORDS-th of a fill are dropped so the counter never wraps.
  assign accept = mem_rvalid && (ret_cnt_q < CNT_W'(WORDS));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    arb_update  = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = '0;
    fill_valid  = 1'b0;
    fill_idx    = '0;
    fill_data   = '0;
    tag_write   = 1'b0;
    fill_done   = '0;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          state_d     = StIssue;
          grant_d     = arb_grant;
          base_d      = sel_addr & ~OFF_MASK;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          arb_update  = 1'b1;
        end
      end
      StIssue, StDrain: begin
        fill_valid = accept;
        fill_idx   = ret_cnt_q[IDX_W-1:0];
        fill_data  = mem_rdata;
        if (accept) begin
          ret_cnt_d = ret_cnt_q + 1'b1;
        end
        if (state_q == StIssue) begin
          mem_en      = 1'b1;
          mem_addr    = base_q + ADDR_W'(issue_cnt_q) * ADDR_W'(BYTES);
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == CNT_W'(WORDS - 1)) begin
            state_d = StDrain;
          end
        end else if (ret_cnt_d == CNT_W'(WORDS)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        tag_write = 1'b1;
        fill_done = grant_q;
        grant_d   = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy  = (state_q != StIdle);
  assign grant = grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Directed bench for cache_miss_arbiter with a 4-cycle-latency memory model.
module tb_cache_miss_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [31:0] req_addr = '0;
  logic        busy;
  logic [1:0]  grant;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        fill_valid;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data;
  logic        tag_write;
  logic [1:0]  fill_done;
  logic        spur = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  cache_miss_arbiter #(
    .ADDR_W (16),
    .DATA_W (16),
    .WORDS  (8),
    .NUM_CH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .busy       (busy),
    .grant      (grant),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .fill_valid (fill_valid),
    .fill_idx   (fill_idx),
    .fill_data  (fill_data),
    .tag_write  (tag_write),
    .fill_done  (fill_done)
  );

  always #5 clk = ~clk;

  // Memory: read issued in cycle t returns in cycle t+4; shares rst with the DUT.
  logic [3:0]  pv;
  logic [15:0] pa0, pa1, pa2, pa3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv  <= '0;
      pa0 <= '0;
      pa1 <= '0;
      pa2 <= '0;
      pa3 <= '0;
    end else begin
      pv  <= {pv[2:0], mem_en};
      pa0 <= mem_addr;
      pa1 <= pa0;
      pa2 <= pa1;
      pa3 <= pa2;
    end
  end
  assign mem_rvalid = pv[3] | spur;
  assign mem_rdata  = pv[3] ? (pa3 ^ 16'h5A5A) : 16'hDEAD;

  // Called in cycle 0 of a fill (DUT idle, owner request visible); returns in cycle 14.
  task automatic run_fill(input string name, input logic [1:0] exp_grant,
                          input logic [15:0] exp_base, input int drop_at, input bit scramble);
    logic        eb, emen, efv, etw;
    logic [1:0]  eg, efd;
    logic [15:0] ema, efd16;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (c == drop_at) req_valid = req_valid & ~exp_grant;
      if (scramble && c == 2) req_addr = ~req_addr;
      if (c >= 13) begin
        spur = 1'b1;
        #1;
      end
      eb    = (c <= 13);
      eg    = (c <= 13) ? exp_grant : 2'b00;
      emen  = (c >= 1 && c <= 8);
      ema   = emen ? exp_base + 16'(2 * (c - 1)) : 16'h0000;
      efv   = (c >= 5 && c <= 12);
      efd16 = (exp_base + 16'(2 * (c - 5))) ^ 16'h5A5A;
      etw   = (c == 13);
      efd   = (c == 13) ? exp_grant : 2'b00;
      n_cmp++;
      if (busy !== eb) begin
        n_bad++;
        $display("FAIL %s busy c=%0d got %0b want %0b", name, c, busy, eb);
      end
      n_cmp++;
      if (grant !== eg) begin
        n_bad++;
        $display("FAIL %s grant c=%0d got %b want %b", name, c, grant, eg);
      end
      n_cmp++;
      if (mem_en !== emen || mem_addr !== ema) begin
        n_bad++;
        $display("FAIL %s mem c=%0d got en=%0b addr=%h want en=%0b addr=%h",
                 name, c, mem_en, mem_addr, emen, ema);
      end
      n_cmp++;
      if (fill_valid !== efv) begin
        n_bad++;
        $display("FAIL %s fill_valid c=%0d got %0b want %0b", name, c, fill_valid, efv);
      end
      if (efv) begin
        n_cmp++;
        if (fill_idx !== 3'(c - 5) || fill_data !== efd16) begin
          n_bad++;
          $display("FAIL %s fill_word c=%0d got idx=%0d data=%h want idx=%0d data=%h",
                   name, c, fill_idx, fill_data, c - 5, efd16);
        end
      end
      n_cmp++;
      if (tag_write !== etw || fill_done !== efd) begin
        n_bad++;
        $display("FAIL %s done c=%0d got tw=%0b fd=%b want tw=%0b fd=%b",
                 name, c, tag_write, fill_done, etw, efd);
      end
      spur = 1'b0;
    end
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    req_addr  = 32'h8008_0040;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, grant, mem_en, mem_addr, fill_valid, fill_idx, fill_data, tag_write,
         fill_done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%0b grant=%b mem_en=%0b addr=%h fv=%0b want all 0",
               busy, grant, mem_en, mem_addr, fill_valid);
    end
    req_valid = 2'b00;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset busy got %0b want 0", busy);
    end
  endtask

  task automatic test_single_miss();
    req_addr  = 32'h0000_1234;
    req_valid = 2'b01;
    run_fill("single", 2'b01, 16'h1230, 1, 1'b1);
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_addr  = 32'h8008_0040;
    req_valid = 2'b11;
    run_fill("simul_ch0", 2'b01, 16'h0040, 3, 1'b0);
    run_fill("simul_ch1", 2'b10, 16'h8000, 3, 1'b0);
  endtask

  task automatic test_arbitration_order();
    logic [1:0]  eg[4];
    logic [15:0] eb[4];
`ifdef CACHE_MISS_RR_ARB_EN
    eg = '{2'b01, 2'b10, 2'b01, 2'b10};
    eb = '{16'h0040, 16'h8000, 16'h0040, 16'h8000};
`else
    eg = '{2'b01, 2'b01, 2'b01, 2'b01};
    eb = '{16'h0040, 16'h0040, 16'h0040, 16'h0040};
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_addr  = 32'h8008_0040;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run_fill($sformatf("arb_fill%0d", i), eg[i], eb[i], 0, 1'b0);
    end
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL arb_end busy got %0b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    req_addr  = 32'h0000_2468;
    req_valid = 2'b01;
    repeat (6) @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, grant, mem_en, mem_addr, fill_valid, fill_idx, fill_data, tag_write,
         fill_done} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs got busy=%0b grant=%b mem_en=%0b tw=%0b want all 0",
               busy, grant, mem_en, tag_write);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy || fill_valid || tag_write || fill_done != 2'b00) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL midreset_quiet got activity=1 want 0");
    end
    req_addr  = 32'h0000_0ABC;
    req_valid = 2'b01;
    run_fill("midreset_fresh", 2'b01, 16'h0AB0, 1, 1'b0);
  endtask

  task automatic test_spurious_idle();
    for (int c = 0; c < 4; c++) begin
      spur = 1'b1;
      #1;
      n_cmp++;
      if (fill_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL spurious_idle c=%0d got fv=%0b busy=%0b want 0 0", c, fill_valid, busy);
      end
      @(posedge clk);
      #1;
    end
    spur = 1'b0;
    req_addr  = 32'h0000_0102;
    req_valid = 2'b10;
    req_addr  = 32'h0102_0000;
    run_fill("after_spurious", 2'b10, 16'h0100, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_simultaneous();
    test_arbitration_order();
    test_reset_mid_fill();
    test_spurious_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
